// File: rtl/event_wake_pkg.sv
// +-----------------------------------------------------------------------------+
// | event_wake_pkg : shared constants for the event/timer wake controller       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package event_wake_pkg;

   // Word offsets, decoded on PADDR[4:2]
   localparam logic [2:0] REG_MASK       = 3'd0;
   localparam logic [2:0] REG_PENDING    = 3'd1;
   localparam logic [2:0] REG_CLEAR      = 3'd2;
   localparam logic [2:0] REG_TIMER_CMP  = 3'd3;
   localparam logic [2:0] REG_TIMER_CTRL = 3'd4;
   localparam logic [2:0] REG_TIMER_VAL  = 3'd5;
   localparam logic [2:0] REG_ID         = 3'd6;
   localparam logic [2:0] REG_WAKE_CNT   = 3'd7;

   localparam int TCTRL_EN_BIT      = 0;
   localparam int TCTRL_ONESHOT_BIT = 1;
   localparam int ID_VALID_BIT      = 31;

   localparam logic [0:0] ST_AWAKE  = 1'b0;
   localparam logic [0:0] ST_ASLEEP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/wake_timer.sv
// +-----------------------------------------------------------------------------+
// | wake_timer : compare timer with one-shot mode, emits a single-cycle fire    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module wake_timer
   import event_wake_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmp_we_i,
   input  logic        ctrl_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] cmp_o,
   output logic [1:0]  ctrl_o,
   output logic [31:0] cnt_o,
   output logic        fire_o
);

   logic [31:0] cmp_q, cmp_d;
   logic [31:0] cnt_q, cnt_d;
   logic        en_q, en_d;
   logic        oneshot_q, oneshot_d;

   assign fire_o = en_q && (cnt_q == cmp_q);

   always_comb begin
      cmp_d     = cmp_q;
      cnt_d     = cnt_q;
      en_d      = en_q;
      oneshot_d = oneshot_q;
      if (en_q) begin
         if (fire_o) begin
            cnt_d = '0;
            if (oneshot_q) en_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
      // Software reprogramming restarts the count and overrides the one-shot disable
      if (cmp_we_i) begin
         cmp_d = wdata_i;
         cnt_d = '0;
      end
      if (ctrl_we_i) begin
         en_d      = wdata_i[TCTRL_EN_BIT];
         oneshot_d = wdata_i[TCTRL_ONESHOT_BIT];
         cnt_d     = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmp_q     <= '0;
         cnt_q     <= '0;
         en_q      <= 1'b0;
         oneshot_q <= 1'b0;
      end else begin
         cmp_q     <= cmp_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         oneshot_q <= oneshot_d;
      end
   end

   assign cmp_o  = cmp_q;
   assign ctrl_o = {oneshot_q, en_q};
   assign cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/event_wake_ctrl.sv
// +-----------------------------------------------------------------------------+
// | event_wake_ctrl : APB wake-source controller (edge capture, mask, ID, count)|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module event_wake_ctrl
   import event_wake_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NB_EVENTS      = 8
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [NB_EVENTS-1:0]      event_i,
   input  logic                      core_sleeping_i,
   output logic                      wake_o
);

   localparam int NB_SRC = NB_EVENTS + 1;

   logic [NB_EVENTS-1:0] event_q;
   logic [NB_SRC-1:0]    pending_q, pending_d;
   logic [NB_SRC-1:0]    mask_q, mask_d;
   logic                 wake_q;
   logic [0:0]           state_q, state_d;
   logic [31:0]          wake_cnt_q, wake_cnt_d;

   logic                 apb_wr, apb_rd;
   logic [2:0]           addr;
   logic [NB_SRC-1:0]    active, lowest, set_vec, clr_vec;
   logic                 id_valid;
   logic [4:0]           id_idx;
   logic                 wake_inc;
   logic [31:0]          tmr_cmp, tmr_cnt;
   logic [1:0]           tmr_ctrl;
   logic                 tmr_fire;
   logic                 w_unused_ok;

   assign apb_wr  = PSEL && PENABLE && PWRITE;
   assign apb_rd  = PSEL && PENABLE && !PWRITE;
   assign addr    = PADDR[4:2];
   assign PREADY  = 1'b1;
   assign PSLVERR = 1'b0;
   assign w_unused_ok = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

   wake_timer u_timer (
      .clk_i     (HCLK),
      .rst_ni    (HRESETn),
      .cmp_we_i  (apb_wr && (addr == REG_TIMER_CMP)),
      .ctrl_we_i (apb_wr && (addr == REG_TIMER_CTRL)),
      .wdata_i   (PWDATA),
      .cmp_o     (tmr_cmp),
      .ctrl_o    (tmr_ctrl),
      .cnt_o     (tmr_cnt),
      .fire_o    (tmr_fire)
   );

   assign active = pending_q & mask_q;
   // Isolate the lowest set bit; this is the source acknowledged by an ID read
   assign lowest = active & ~(active - NB_SRC'(1));

   always_comb begin
      id_valid = 1'b0;
      id_idx   = '0;
      for (int i = NB_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            id_valid = 1'b1;
            id_idx   = 5'(i);
         end
      end
   end

   always_comb begin
      set_vec = {tmr_fire, event_i & ~event_q};
      clr_vec = '0;
      if (apb_wr && (addr == REG_CLEAR)) clr_vec = PWDATA[NB_SRC-1:0];
      if (apb_rd && (addr == REG_ID))    clr_vec = clr_vec | lowest;
      // A same-cycle set outranks any clear
      pending_d = (pending_q & ~clr_vec) | set_vec;
      mask_d    = (apb_wr && (addr == REG_MASK)) ? PWDATA[NB_SRC-1:0] : mask_q;
   end

   always_comb begin
      state_d  = state_q;
      wake_inc = 1'b0;
      case (state_q)
         ST_AWAKE:  if (core_sleeping_i) state_d = ST_ASLEEP;
         ST_ASLEEP: if (!core_sleeping_i) begin
            state_d  = ST_AWAKE;
            wake_inc = 1'b1;
         end
         default:   state_d = ST_AWAKE;
      endcase
      if (apb_wr && (addr == REG_WAKE_CNT)) wake_cnt_d = PWDATA;
      else                                  wake_cnt_d = wake_cnt_q + {31'd0, wake_inc};
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         event_q    <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         wake_q     <= 1'b0;
         state_q    <= ST_AWAKE;
         wake_cnt_q <= '0;
      end else begin
         event_q    <= event_i;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         wake_q     <= |active;
         state_q    <= state_d;
         wake_cnt_q <= wake_cnt_d;
      end
   end

   always_comb begin
      PRDATA = '0;
      if (apb_rd) begin
         case (addr)
            REG_MASK:       PRDATA = 32'(mask_q);
            REG_PENDING:    PRDATA = 32'(pending_q);
            REG_TIMER_CMP:  PRDATA = tmr_cmp;
            REG_TIMER_CTRL: PRDATA = {30'd0, tmr_ctrl};
            REG_TIMER_VAL:  PRDATA = tmr_cnt;
            REG_ID: begin
               PRDATA[ID_VALID_BIT] = id_valid;
               PRDATA[4:0]          = id_idx;
            end
            REG_WAKE_CNT:   PRDATA = wake_cnt_q;
            default:        PRDATA = '0;
         endcase
      end
   end

   assign wake_o = wake_q;

endmodule

`default_nettype wire
